// File: rtl/tdm_mux4_tx.sv
// Transmit end of a 1x4 TDM demux link: grants one of four requesters per cycle onto (A, din).
// Define TDM_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest requesting index wins.
module tdm_mux4_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic [3:0] D,
  output logic [3:0] ack,
  output logic [1:0] A,
  output logic       din,
  output logic       vld
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_nextState;

  logic [1:0] r_ptr;
  logic [1:0] r_A;
  logic       r_din;
  logic [3:0] r_ack;

  logic       w_grant;
  logic [1:0] w_grantIdx;

`ifdef TDM_ROUND_ROBIN_EN
  logic [1:0] w_cand;
  logic       w_found;

  // Search starts just after the last-granted channel; 2-bit addition gives the 3->0 wrap.
  always_comb begin
    w_grant    = en && (req != 4'b0000);
    w_grantIdx = 2'd0;
    w_cand     = 2'd0;
    w_found    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_found && req[w_cand]) begin
        w_grantIdx = w_cand;
        w_found    = 1'b1;
      end
    end
  end
`else
  // The pointer is still tracked in this mode but plays no part in arbitration.
  logic w_unusedPtr;
  assign w_unusedPtr = ^r_ptr;

  always_comb begin
    w_grant    = en && (req != 4'b0000);
    w_grantIdx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) begin
        w_grantIdx = 2'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = IDLE;
    if (w_grant) begin
      w_nextState = SEND;
    end
  end

  // A and din keep their last transfer while idle; only ack is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_A   <= 2'b00;
      r_din <= 1'b0;
      r_ack <= 4'b0000;
      r_ptr <= 2'b11;
    end else if (w_grant) begin
      r_A   <= w_grantIdx;
      r_din <= D[w_grantIdx];
      r_ack <= 4'b0001 << w_grantIdx;
      r_ptr <= w_grantIdx;
    end else begin
      r_ack <= 4'b0000;
    end
  end

  always_comb begin
    vld = (r_state == SEND);
    ack = r_ack;
    A   = r_A;
    din = r_din;
  end

endmodule

// File: tb/tb_tdm_mux4_tx.sv
// Self-checking bench for tdm_mux4_tx: directed vectors plus randomized traffic against a behavioural model.
module tb_tdm_mux4_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] D;
  logic [3:0] ack;
  logic [1:0] A;
  logic       din;
  logic       vld;

  int testCount = 0;
  int failCount = 0;

  int         mPtr;
  logic [1:0] mA;
  logic       mDin;
  logic       mVld;
  logic [3:0] mAck;

  tdm_mux4_tx dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req(req),
    .D(D),
    .ack(ack),
    .A(A),
    .din(din),
    .vld(vld)
  );

  always #5 clk = ~clk;

  function automatic int pickGrant(input logic [3:0] r, input int p);
`ifdef TDM_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
`else
    for (int c = 0; c < 4; c++) begin
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic modelReset();
    mPtr = 3;
    mA   = 2'b00;
    mDin = 1'b0;
    mVld = 1'b0;
    mAck = 4'b0000;
  endtask

  task automatic modelEdge();
    int g;
    g = en ? pickGrant(req, mPtr) : -1;
    if (g >= 0) begin
      mA   = 2'(g);
      mDin = D[g];
      mVld = 1'b1;
      mAck = 4'b0001 << g;
      mPtr = g;
    end else begin
      mVld = 1'b0;
      mAck = 4'b0000;
    end
  endtask

  task automatic checkOutput(input string tag);
    testCount++;
    assert (A === mA) else begin
      failCount++;
      $error("FAIL %s A: got %0d expected %0d", tag, A, mA);
    end
    testCount++;
    assert (din === mDin) else begin
      failCount++;
      $error("FAIL %s din: got %0b expected %0b", tag, din, mDin);
    end
    testCount++;
    assert (vld === mVld) else begin
      failCount++;
      $error("FAIL %s vld: got %0b expected %0b", tag, vld, mVld);
    end
    testCount++;
    assert (ack === mAck) else begin
      failCount++;
      $error("FAIL %s ack: got %4b expected %4b", tag, ack, mAck);
    end
  endtask

  task automatic checkConst(input string tag, input logic [1:0] eA, input logic eDin,
                            input logic eVld, input logic [3:0] eAck);
    testCount++;
    assert ((A === eA) && (din === eDin) && (vld === eVld) && (ack === eAck)) else begin
      failCount++;
      $error("FAIL %s: got A=%0d din=%0b vld=%0b ack=%4b expected A=%0d din=%0b vld=%0b ack=%4b",
             tag, A, din, vld, ack, eA, eDin, eVld, eAck);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] r, input logic [3:0] d,
                               input string tag);
    en  = e;
    req = r;
    D   = d;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  // Called 1 time unit after a rising edge; the reset pulse lies entirely between edges.
  task automatic pulseReset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput(tag);
    rst = 1'b0;
  endtask

  initial begin
    int i;
    logic e;
    logic [3:0] r;
    logic [3:0] d;

    rst = 1'b1;
    en  = 1'b1;
    req = 4'b1111;
    D   = 4'b1111;
    modelReset();
    #2;
    checkOutput("reset_immediate");
    checkConst("reset_immediate_const", 2'd0, 1'b0, 1'b0, 4'b0000);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold");
      checkConst("reset_hold_const", 2'd0, 1'b0, 1'b0, 4'b0000);
    end
    rst = 1'b0;

    repeat (3) begin
      applyStimulus(1'b1, 4'b0100, 4'b0100, "single_ch2");
      checkConst("single_ch2_const", 2'd2, 1'b1, 1'b1, 4'b0100);
    end

    pulseReset("rst_before_seq");
    for (i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b1111, 4'b1010, "arb_seq");
`ifdef TDM_ROUND_ROBIN_EN
      checkConst("rr_seq_const", 2'(i % 4), 1'(i % 2), 1'b1, 4'b0001 << (i % 4));
`else
      checkConst("fixed_seq_const", 2'd0, 1'b0, 1'b1, 4'b0001);
`endif
    end

    pulseReset("rst_before_gap");
`ifdef TDM_ROUND_ROBIN_EN
    applyStimulus(1'b1, 4'b0011, 4'b0011, "gap_grant0");
    applyStimulus(1'b1, 4'b0011, 4'b0011, "gap_grant1");
`else
    applyStimulus(1'b1, 4'b0010, 4'b0011, "gap_grant1");
`endif
    checkConst("gap_grant1_const", 2'd1, 1'b1, 1'b1, 4'b0010);
    repeat (2) begin
      applyStimulus(1'b0, 4'b0011, 4'b0011, "gap_idle");
      checkConst("gap_idle_const", 2'd1, 1'b1, 1'b0, 4'b0000);
    end
    applyStimulus(1'b1, 4'b0011, 4'b0011, "gap_resume");
    checkConst("gap_resume_const", 2'd0, 1'b1, 1'b1, 4'b0001);

    applyStimulus(1'b1, 4'b1111, 4'b1111, "pre_async_rst");
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_rst");
    checkConst("async_rst_const", 2'd0, 1'b0, 1'b0, 4'b0000);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 4'b1000, 4'b1000, "post_rst_grant");
    checkConst("post_rst_grant_const", 2'd3, 1'b1, 1'b1, 4'b1000);

    for (i = 0; i < 300; i++) begin
      e = ($urandom_range(0, 7) != 0);
      r = 4'($urandom);
      d = 4'($urandom);
      applyStimulus(e, r, d, "random");
      if ($urandom_range(0, 24) == 0) begin
        pulseReset("random_async_rst");
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/tdm_mux4_tx.md
TDM_MUX4_TX -- requirements
Module: tdm_mux4_tx

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Ports SHALL be exactly, in this order:
- clk  input  1  rising-edge clock
- rst  input  1  async active-high reset
- en  input  1  arbitration enable
- req  input  4  per-channel send request, bit i = channel i
- D  input  4  per-channel data bit
- ack  output  1x4 (4)  one-cycle grant pulse to the served channel
- A  output  2  select/address of the channel in dout, drives DEMUX1X4 A
- din  output  1  serialized data bit, drives DEMUX1X4 din
- vld  output  1  din/A hold a valid transfer this cycle

Function
REQ-003 The block SHALL act as the transmit end of a 1x4 demux link: it multiplexes 4 requesting channels onto one (A, din) pair, one channel per cycle.
REQ-004 FSM states SHALL be IDLE (vld=0) and SEND (vld=1).
REQ-005 On each rising edge with en=1 and req!=0, the FSM SHALL go to SEND and register: A<=granted index g, din<=D[g], vld<=1, ack<=one-hot(g).
REQ-006 On each rising edge with en=0 or req==0, the FSM SHALL go to IDLE and register: vld<=0, ack<=0; A and din SHALL hold their last values.
REQ-007 Latency SHALL be exactly 1 cycle: req[g]/D[g] sampled at edge N appear on A/din/vld/ack after edge N.
REQ-008 At most one ack bit SHALL be high per cycle; ack SHALL never be high while vld=0.
REQ-009 A requester SHALL hold req[i] and D[i] stable until it sees ack[i]; if it drops req[i] before grant, no transfer for channel i SHALL occur.
REQ-010 A channel with req held high continuously SHALL be granted on consecutive cycles when no other channel requests.
REQ-011 Arbitration SHALL use a 2-bit last-grant pointer P, updated to g on every grant and unchanged otherwise.
REQ-012 With round-robin enabled, the search SHALL start at (P+1) mod 4 and wrap 3->0; a requesting channel SHALL wait at most 3 grants.
REQ-013 Deasserting en mid-stream SHALL complete no partial transfer; the next edge SHALL produce IDLE, and P SHALL be retained.
REQ-014 req and D changes between edges SHALL have no effect on outputs until the next edge.

Reset
REQ-015 While rst=1, state SHALL be IDLE and outputs SHALL be A=2'b00, din=0, vld=0, ack=4'b0000, with P=2'b11 so that channel 0 is searched first.
REQ-016 Assertion of rst mid-transfer SHALL clear all outputs immediately, without waiting for clk; the first grant after release SHALL occur at the first edge with en=1 and req!=0.

Configuration
REQ-017 Macro TDM_ROUND_ROBIN_EN SHALL select the arbitration scheme.
- Defined: round-robin per REQ-012.
- Undefined: fixed priority, lowest requesting index wins; P is still maintained but ignored, and starvation of channels 1-3 is permitted.

Verification
REQ-018 Reset: rst=1 with req=4'b1111, en=1 -> A=0, din=0, vld=0, ack=0 immediately, and they stay so until release.
REQ-019 Single channel: en=1, req=4'b0100, D=4'b0100 -> next cycle A=2, din=1, vld=1, ack=4'b0100; repeats each cycle while held.
REQ-020 Round-robin (macro defined): req=4'b1111, D=4'b1010 held for 5 cycles -> A sequence 0,1,2,3,0; din sequence 0,1,0,1,0.
REQ-021 Fixed priority (macro undefined): same stimulus as REQ-020 -> A=0 and din=0 on all 5 cycles; ack=4'b0001 every cycle.
REQ-022 Enable gap: after a grant on channel 1 with req=4'b0011, hold en=0 for 2 cycles -> vld=0, ack=0, A=1 held; restore en=1 -> A=0 (macro defined), because P is retained.
REQ-023 Async reset mid-stream: assert rst between edges while vld=1 -> vld and ack drop before the next edge; after release with req=4'b1000 -> first grant has A=3.
